// File: rtl/sdma_inst_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdma_inst_scheduler_pkg
// Purpose : Shared definitions for the SDMA instruction scheduler: scheduler
//           FSM state encoding, default engine count and counter width, and
//           the sdmamode field location inside an SDMA instruction word.
// Revision: 1.0 - initial release
// ============================================================================
package sdma_inst_scheduler_pkg;

    // Instruction word geometry; the sdmamode field occupies the top nibble.
    localparam int c_sdma_instwidth          = 32;
    localparam int c_sdma_inst_sdmamodestart = 28;
    localparam int c_sdma_inst_sdmamodewidth = 4;

    // Sub-engine array size and completed-instruction counter width.
    localparam int c_sdma_num_eng = 8;
    localparam int c_sdma_cnt_w   = 16;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        SDMA_SIS_IDLE  = 2'd0,
        SDMA_SIS_ISSUE = 2'd1,
        SDMA_SIS_WAIT  = 2'd2
    } sis_state_t;

endpackage : sdma_inst_scheduler_pkg
`default_nettype wire

// File: rtl/sdma_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sdma_sync_fifo
// Purpose : Single-clock FIFO with full/empty flags and occupancy count.
//           The head entry is presented combinationally on o_data.
// Ports   : i_clk, i_rst (async, active-high)
//           i_push/i_data  - write request; ignored while full
//           i_pop          - read request; ignored while empty
//           o_data         - head entry
//           o_full/o_empty - status flags
//           o_cnt          - number of stored entries
// Revision: 1.0 - initial release
// ============================================================================
module sdma_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_cnt;

    logic w_push;
    logic w_pop;

    // A push is refused while full even if a pop occurs in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    assign o_full  = (r_cnt == c_cw'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + c_cw'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - c_cw'(1);
            end
        end
    end

    // Storage needs no reset: occupancy tracking guards every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule : sdma_sync_fifo
`default_nettype wire

// File: rtl/sdma_inst_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sdma_inst_scheduler
// Purpose : Front-end sequencer for the SDMA engine cluster. Buffers host
//           instructions, pops them in order and dispatches each to the
//           sub-engine selected by its sdmamode field via start/done,
//           with a single instruction in flight at a time.
// Ports   : i_clk, i_rst (async, active-high)
//           i_sis_inst_valid / o_sis_inst_ready / i_sis_inst - host port
//           o_sis_inst        - current instruction, held until IDLE
//           o_sis_eng_start   - one-hot single-cycle start pulse
//           i_sis_eng_done    - per-engine done pulses
//           o_sis_busy/idle   - status
//           o_sis_fifo_cnt    - FIFO occupancy
//           o_sis_err_illegal - sticky illegal-mode flag, i_sis_err_clr clears
//           o_sis_done_cnt    - wrapping completed-instruction count
// Revision: 1.0 - initial release
// ============================================================================
module sdma_inst_scheduler
    import sdma_inst_scheduler_pkg::*;
#(
    parameter int INST_W   = c_sdma_instwidth,
    parameter int MODE_LSB = c_sdma_inst_sdmamodestart,
    parameter int MODE_W   = c_sdma_inst_sdmamodewidth,
    parameter int NUM_ENG  = c_sdma_num_eng,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = c_sdma_cnt_w
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sis_inst_valid,
    output logic                     o_sis_inst_ready,
    input  logic [INST_W-1:0]        i_sis_inst,
    output logic [INST_W-1:0]        o_sis_inst,
    output logic [NUM_ENG-1:0]       o_sis_eng_start,
    input  logic [NUM_ENG-1:0]       i_sis_eng_done,
    output logic                     o_sis_busy,
    output logic                     o_sis_idle,
    output logic [$clog2(DEPTH):0]   o_sis_fifo_cnt,
    output logic                     o_sis_err_illegal,
    input  logic                     i_sis_err_clr,
    output logic [CNT_W-1:0]         o_sis_done_cnt
);

    sis_state_t         r_state;
    sis_state_t         w_state_nxt;
    logic [INST_W-1:0]  r_inst;
    logic               r_busy;
    logic               r_err;
    logic [CNT_W-1:0]   r_done_cnt;

    logic [INST_W-1:0]  w_fifo_data;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic [MODE_W-1:0]  w_mode;
    logic [NUM_ENG-1:0] w_sel;
    logic               w_legal;
    logic               w_err_set;
    logic               w_done_hit;

    sdma_sync_fifo #(
        .WIDTH (INST_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_sis_inst_valid),
        .i_data  (i_sis_inst),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_cnt   (o_sis_fifo_cnt)
    );

    assign o_sis_inst_ready = !w_fifo_full;

    // One-hot engine select decoded from the held instruction. A mode at or
    // above NUM_ENG decodes to all zeros, which doubles as the legality test.
    assign w_mode = r_inst[MODE_LSB +: MODE_W];

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_sel[i] = ({{(32-MODE_W){1'b0}}, w_mode} == i[31:0]);
        end
    end

    assign w_legal = |w_sel;

    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        o_sis_eng_start = '0;
        w_err_set       = 1'b0;
        w_done_hit      = 1'b0;
        case (r_state)
            SDMA_SIS_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SDMA_SIS_ISSUE;
                end
            end
            SDMA_SIS_ISSUE: begin
                if (w_legal) begin
                    o_sis_eng_start = w_sel;
                    w_state_nxt     = SDMA_SIS_WAIT;
                end else begin
                    w_err_set   = 1'b1;
                    w_state_nxt = SDMA_SIS_IDLE;
                end
            end
            SDMA_SIS_WAIT: begin
                // Only the addressed engine's done bit completes the op.
                if (|(i_sis_eng_done & w_sel)) begin
                    w_done_hit  = 1'b1;
                    w_state_nxt = SDMA_SIS_IDLE;
                end
            end
            default: begin
                w_state_nxt = SDMA_SIS_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= SDMA_SIS_IDLE;
            r_inst     <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != SDMA_SIS_IDLE);
            if (w_pop) begin
                r_inst <= w_fifo_data;
            end
            // A new illegal instruction takes priority over a clear request.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_sis_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_done_hit) begin
                r_done_cnt <= r_done_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sis_inst        = r_inst;
    assign o_sis_busy        = r_busy;
    assign o_sis_idle        = (r_state == SDMA_SIS_IDLE) && w_fifo_empty;
    assign o_sis_err_illegal = r_err;
    assign o_sis_done_cnt    = r_done_cnt;

endmodule : sdma_inst_scheduler
`default_nettype wire

// File: tb/tb_sdma_inst_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdma_inst_scheduler
// Purpose : Self-checking bench for sdma_inst_scheduler: a cycle-by-cycle
//           vector table plus hand-written multi-cycle sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdma_inst_scheduler;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [31:0] inst_in;
    logic [31:0] inst_out;
    logic [7:0]  start;
    logic [7:0]  done;
    logic        busy;
    logic        idle;
    logic [2:0]  fifo_cnt;
    logic        err;
    logic        clr;
    logic [3:0]  dc;

    int n_tests = 0;
    int n_fail  = 0;

    sdma_inst_scheduler #(
        .INST_W   (32),
        .MODE_LSB (28),
        .MODE_W   (4),
        .NUM_ENG  (8),
        .DEPTH    (4),
        .CNT_W    (4)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_sis_inst_valid  (valid),
        .o_sis_inst_ready  (ready),
        .i_sis_inst        (inst_in),
        .o_sis_inst        (inst_out),
        .o_sis_eng_start   (start),
        .i_sis_eng_done    (done),
        .o_sis_busy        (busy),
        .o_sis_idle        (idle),
        .o_sis_fifo_cnt    (fifo_cnt),
        .o_sis_err_illegal (err),
        .i_sis_err_clr     (clr),
        .o_sis_done_cnt    (dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [7:0]  done;
        logic        clr;
        logic        e_ready;
        logic [7:0]  e_start;
        logic        e_busy;
        logic        e_idle;
        logic [2:0]  e_cnt;
        logic        e_err;
        logic [3:0]  e_dc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input int mode, input int tag);
        logic [3:0]  m;
        logic [27:0] t;
        m = 4'(mode);
        t = 28'(tag);
        return {m, t};
    endfunction

    function automatic void add(input logic v, input logic [31:0] in,
                                input logic [7:0] d, input logic c,
                                input logic er, input logic [7:0] es,
                                input logic eb, input logic ei,
                                input logic [2:0] ec, input logic ee,
                                input logic [3:0] ed, input logic [31:0] einst);
        vec_t r;
        r.valid = v;   r.inst = in;    r.done = d;    r.clr = c;
        r.e_ready = er; r.e_start = es; r.e_busy = eb; r.e_idle = ei;
        r.e_cnt = ec;  r.e_err = ee;   r.e_dc = ed;   r.e_inst = einst;
        vq.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, 32'(ready), 32'd1);
        chk({pfx, "_inst"},  inst_out,   32'd0);
        chk({pfx, "_start"}, 32'(start), 32'd0);
        chk({pfx, "_busy"},  32'(busy),  32'd0);
        chk({pfx, "_idle"},  32'(idle),  32'd1);
        chk({pfx, "_cnt"},   32'(fifo_cnt), 32'd0);
        chk({pfx, "_err"},   32'(err),   32'd0);
        chk({pfx, "_dc"},    32'(dc),    32'd0);
    endtask

    // Called at negedge+1 of a cycle before the instruction's ISSUE; waits
    // (bounded) for the start pulse, checks it, then returns done.
    task automatic dispatch(input int k, input logic [31:0] exp_inst);
        int n;
        n = 0;
        while (start == 8'd0 && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk($sformatf("disp%0d_start", k), 32'(start), 32'(8'(1 << k)));
        chk($sformatf("disp%0d_inst", k), inst_out, exp_inst);
        @(negedge clk);
        done = 8'(1 << k);
        @(negedge clk);
        done = 8'd0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] i3, i9, i1, i2;
        i3 = mk(3, 'hA1);
        i9 = mk(9, 'hB0);
        i1 = mk(1, 'hB1);
        i2 = mk(2, 'hC2);

        // Single instruction, mode 3: start in cycle 2 only, done in cycle 10.
        add(1, i3, 0, 0,  1, 8'h00, 0, 1, 0, 0, 0, 0);
        add(0, 0,  0, 0,  1, 8'h00, 0, 0, 1, 0, 0, 0);
        add(0, 0,  0, 0,  1, 8'h08, 1, 0, 0, 0, 0, i3);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 0, i3);
        add(0, 0, 8'h08, 0, 1, 8'h00, 1, 0, 0, 0, 0, i3);
        add(0, 0,  0, 0,  1, 8'h00, 0, 1, 0, 0, 1, i3);
        // Illegal mode 9 then mode 1; error clear later.
        add(1, i9, 0, 0,  1, 8'h00, 0, 1, 0, 0, 1, i3);
        add(1, i1, 0, 0,  1, 8'h00, 0, 0, 1, 0, 1, i3);
        add(0, 0,  0, 0,  1, 8'h00, 1, 0, 1, 0, 1, i9);
        add(0, 0,  0, 0,  1, 8'h00, 0, 0, 1, 1, 1, i9);
        add(0, 0,  0, 0,  1, 8'h02, 1, 0, 0, 1, 1, i1);
        add(0, 0, 8'h02, 0, 1, 8'h00, 1, 0, 0, 1, 1, i1);
        add(0, 0,  0, 1,  1, 8'h00, 0, 1, 0, 1, 2, i1);
        add(0, 0,  0, 0,  1, 8'h00, 0, 1, 0, 0, 2, i1);
        // Mode 2: done during ISSUE and wrong-engine done are ignored.
        add(1, i2, 0, 0,  1, 8'h00, 0, 1, 0, 0, 2, i1);
        add(0, 0,  0, 0,  1, 8'h00, 0, 0, 1, 0, 2, i1);
        add(0, 0, 8'h04, 0, 1, 8'h04, 1, 0, 0, 0, 2, i2);
        add(0, 0, 8'h20, 0, 1, 8'h00, 1, 0, 0, 0, 2, i2);
        add(0, 0,  0, 0,  1, 8'h00, 1, 0, 0, 0, 2, i2);
        add(0, 0, 8'h04, 0, 1, 8'h00, 1, 0, 0, 0, 2, i2);
        add(0, 0,  0, 0,  1, 8'h00, 0, 1, 0, 0, 3, i2);

        rst = 1'b1; valid = 1'b0; inst_in = '0; done = '0; clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        foreach (vq[i]) begin
            valid = vq[i].valid; inst_in = vq[i].inst;
            done  = vq[i].done;  clr     = vq[i].clr;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(ready),    32'(vq[i].e_ready));
            chk($sformatf("vec%0d_start", i), 32'(start),    32'(vq[i].e_start));
            chk($sformatf("vec%0d_busy",  i), 32'(busy),     32'(vq[i].e_busy));
            chk($sformatf("vec%0d_idle",  i), 32'(idle),     32'(vq[i].e_idle));
            chk($sformatf("vec%0d_cnt",   i), 32'(fifo_cnt), 32'(vq[i].e_cnt));
            chk($sformatf("vec%0d_err",   i), 32'(err),      32'(vq[i].e_err));
            chk($sformatf("vec%0d_dc",    i), 32'(dc),       32'(vq[i].e_dc));
            chk($sformatf("vec%0d_inst",  i), inst_out,      vq[i].e_inst);
            @(negedge clk);
        end
        valid = 1'b0; done = '0; clr = 1'b0;
        #1;

        // Five back-to-back pushes with done withheld: FIFO fills at 4.
        for (int k = 0; k < 5; k++) begin
            valid = 1'b1; inst_in = mk(k, 'h50 + k);
            #1;
            chk($sformatf("bb_push%0d_ready", k), 32'(ready), 32'd1);
            @(negedge clk);
        end
        valid = 1'b0;
        #1;
        chk("bb_full_ready", 32'(ready), 32'd0);
        chk("bb_full_cnt", 32'(fifo_cnt), 32'd4);
        @(negedge clk); #1;
        chk("bb_hold_ready", 32'(ready), 32'd0);
        done = 8'h01;
        @(negedge clk);
        done = 8'h00;
        #1;
        chk("bb_pop_ready", 32'(ready), 32'd0);
        chk("bb_pop_cnt", 32'(fifo_cnt), 32'd4);
        @(negedge clk); #1;
        chk("bb_reready", 32'(ready), 32'd1);
        chk("bb_reready_cnt", 32'(fifo_cnt), 32'd3);
        for (int k = 1; k < 5; k++) dispatch(k, mk(k, 'h50 + k));
        chk("bb_dc", 32'(dc), 32'd8);
        chk("bb_idle", 32'(idle), 32'd1);

        // Illegal instruction with a simultaneous clear: set wins.
        valid = 1'b1; inst_in = mk(9, 'h99);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("errw_issue_busy", 32'(busy), 32'd1);
        chk("errw_issue_start", 32'(start), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("errw_flag", 32'(err), 32'd1);
        chk("errw_dc", 32'(dc), 32'd8);

        // Counter wrap at CNT_W=4: completions 9..17.
        for (int k = 0; k < 9; k++) begin
            valid = 1'b1; inst_in = mk(6, 'h600 + k);
            @(negedge clk);
            valid = 1'b0;
            #1;
            dispatch(6, mk(6, 'h600 + k));
            if (k == 7) chk("wrap_dc16", 32'(dc), 32'd0);
        end
        chk("wrap_dc17", 32'(dc), 32'd1);

        // Asynchronous reset while waiting with two instructions queued.
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1; inst_in = mk(2, 'h700 + k);
            @(negedge clk);
        end
        valid = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy), 32'd1);
        chk("rstw_cnt", 32'(fifo_cnt), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;
        done = 8'h04;
        @(negedge clk);
        done = 8'h00;
        #1;
        chk("rst_late_busy", 32'(busy), 32'd0);
        chk("rst_late_idle", 32'(idle), 32'd1);
        chk("rst_late_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_late_dc", 32'(dc), 32'd0);
        @(negedge clk); #1;
        chk("rst_late_start", 32'(start), 32'd0);
        chk("rst_late_dc2", 32'(dc), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sdma_inst_scheduler
`default_nettype wire
